hash_ctrl_param: RTL and testbench

- Parametrised successor to the single-hash top: a mining controller that sweeps nonces over up to N_ENTRADAS stored 96-bit headers.
- Drives an external micro-hash core through a req/ack handshake and applies a generalised byte-wise target comparison.
- Emits one result per entry (bounty, nonce, found flag) over a valid/ready port.
- Sits between the host/testbench, the header RAM write path and the hash core; it replaces the fixed 4-entry, free-running top.

---
 rtl/hash_pkg.sv | 40 ++++
 rtl/hash_hdr_ram.sv | 25 ++
 rtl/hash_ctrl_param.sv | 184 ++++++++++++++++++
 tb/tb_hash_ctrl_param.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared types and helpers for the parametrised mining controller.
// The optional attempt counter in hash_ctrl_param is enabled by HASH_CYCLE_COUNT_EN.
package hash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CMP,
        OUT,
        DONE
    } state_e;

    localparam int N_ENTRADAS_DEF = 4;
    localparam int ENTRADA_W_DEF  = 96;
    localparam int NONCE_W_DEF    = 32;
    localparam int H_W_DEF        = 24;
    localparam int CMP_BYTES_DEF  = 2;
    localparam int H_W_MAX        = 64;

    // True when each of the cmp_bytes most-significant bytes of h is strictly below tgt.
    function automatic logic target_match(input logic [H_W_MAX-1:0] h,
                                          input logic [7:0]         tgt,
                                          input int                 h_w,
                                          input int                 cmp_bytes);
        logic               ok;
        logic [H_W_MAX-1:0] sh;
        ok = 1'b1;
        sh = '0;
        for (int k = 0; k < H_W_MAX / 8; k++) begin
            if (k < cmp_bytes) begin
                sh = h >> (h_w - 8 * (k + 1));
                if (sh[7:0] >= tgt) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/hash_hdr_ram.sv
// Header storage: synchronous write, combinational read, contents not reset.
module hash_hdr_ram #(
    parameter int N_ENTRADAS = 4,
    parameter int ENTRADA_W  = 96,
    localparam int AW        = $clog2(N_ENTRADAS)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [ENTRADA_W-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [ENTRADA_W-1:0] rdata_o
);

    logic [ENTRADA_W-1:0] mem_q [N_ENTRADAS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hash_ctrl_param.sv
// Nonce-sweeping mining controller over up to N_ENTRADAS stored headers.
// Define HASH_CYCLE_COUNT_EN to add the res_attempts output.
module hash_ctrl_param
    import hash_pkg::*;
#(
    parameter int                 N_ENTRADAS  = N_ENTRADAS_DEF,
    parameter int                 ENTRADA_W   = ENTRADA_W_DEF,
    parameter int                 NONCE_W     = NONCE_W_DEF,
    parameter int                 H_W         = H_W_DEF,
    parameter int                 CMP_BYTES   = CMP_BYTES_DEF,
    parameter logic [NONCE_W-1:0] NONCE_LIMIT = 32'h0000_FFFF,
    localparam int                AW          = $clog2(N_ENTRADAS),
    localparam int                CW          = AW + 1
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [ENTRADA_W-1:0]         wr_data,
    input  logic [CW-1:0]                num_entradas,
    input  logic [7:0]                   target,
    input  logic                         start,
    output logic                         busy,
    output logic [ENTRADA_W+NONCE_W-1:0] bloque_in,
    output logic                         hash_req,
    input  logic                         hash_ack,
    input  logic [H_W-1:0]               H,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [AW-1:0]                res_idx,
    output logic                         res_found,
    output logic [H_W-1:0]               bounty_out,
    output logic [NONCE_W-1:0]           nonce_valido_out,
`ifdef HASH_CYCLE_COUNT_EN
    output logic [NONCE_W-1:0]           res_attempts,
`endif
    output logic                         fin
);

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [H_W-1:0]       h_q, h_d;
    logic [7:0]           tgt_q, tgt_d;
    logic [AW-1:0]        res_idx_q, res_idx_d;
    logic                 res_found_q, res_found_d;
    logic [H_W-1:0]       bounty_q, bounty_d;
    logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
`ifdef HASH_CYCLE_COUNT_EN
    logic [NONCE_W-1:0]   attempts_q, attempts_d;
`endif

    logic [ENTRADA_W-1:0] hdr;
    logic [CW-1:0]        num_eff;
    logic                 match;
    logic                 last;

    hash_hdr_ram #(
        .N_ENTRADAS (N_ENTRADAS),
        .ENTRADA_W  (ENTRADA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en && !busy),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_q),
        .rdata_o (hdr)
    );

    // Out-of-range entry counts (0 or above capacity) mean "process every slot".
    assign num_eff = (num_entradas == '0 || num_entradas > CW'(N_ENTRADAS))
                     ? CW'(N_ENTRADAS) : num_entradas;
    assign match   = target_match(H_W_MAX'(h_q), tgt_q, H_W, CMP_BYTES);
    assign last    = (CW'(idx_q) == cnt_q - CW'(1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        nonce_d     = nonce_q;
        h_d         = h_q;
        tgt_d       = tgt_q;
        res_idx_d   = res_idx_q;
        res_found_d = res_found_q;
        bounty_d    = bounty_q;
        nonce_out_d = nonce_out_q;
`ifdef HASH_CYCLE_COUNT_EN
        attempts_d  = attempts_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = num_eff;
                    tgt_d   = target;
                    idx_d   = '0;
                    nonce_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (hash_ack) begin
                    h_d     = H;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (match || nonce_q == NONCE_LIMIT) begin
                    res_idx_d   = idx_q;
                    res_found_d = match;
                    bounty_d    = match ? h_q : '0;
                    nonce_out_d = nonce_q;
`ifdef HASH_CYCLE_COUNT_EN
                    attempts_d  = nonce_q + NONCE_W'(1);
`endif
                    state_d     = OUT;
                end else begin
                    nonce_d = nonce_q + NONCE_W'(1);
                    state_d = REQ;
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        nonce_d = '0;
                        state_d = REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            nonce_q     <= '0;
            h_q         <= '0;
            tgt_q       <= '0;
            res_idx_q   <= '0;
            res_found_q <= 1'b0;
            bounty_q    <= '0;
            nonce_out_q <= '0;
`ifdef HASH_CYCLE_COUNT_EN
            attempts_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            nonce_q     <= nonce_d;
            h_q         <= h_d;
            tgt_q       <= tgt_d;
            res_idx_q   <= res_idx_d;
            res_found_q <= res_found_d;
            bounty_q    <= bounty_d;
            nonce_out_q <= nonce_out_d;
`ifdef HASH_CYCLE_COUNT_EN
            attempts_q  <= attempts_d;
`endif
        end
    end

    // Outputs decode straight from the state register so reset clears them at once.
    assign hash_req         = (state_q == REQ);
    assign bloque_in        = hash_req ? {hdr, nonce_q} : '0;
    assign res_valid        = (state_q == OUT);
    assign fin              = (state_q == DONE);
    assign busy             = (state_q == REQ) || (state_q == CMP) || (state_q == OUT);
    assign res_idx          = res_idx_q;
    assign res_found        = res_found_q;
    assign bounty_out       = bounty_q;
    assign nonce_valido_out = nonce_out_q;
`ifdef HASH_CYCLE_COUNT_EN
    assign res_attempts     = attempts_q;
`endif

endmodule

// File: tb/tb_hash_ctrl_param.sv
// Self-checking bench for hash_ctrl_param with a hash-core model and a result reference model.
module tb_hash_ctrl_param;

    localparam int          N     = 4;
    localparam logic [31:0] LIMIT = 32'd7;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_addr = '0;
    logic [95:0]  wr_data = '0;
    logic [2:0]   num_entradas = '0;
    logic [7:0]   target = '0;
    logic         start = 1'b0;
    logic         busy;
    logic [127:0] bloque_in;
    logic         hash_req;
    logic         hash_ack = 1'b0;
    logic [23:0]  H = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [1:0]   res_idx;
    logic         res_found;
    logic [23:0]  bounty_out;
    logic [31:0]  nonce_valido_out;
    logic         fin;
`ifdef HASH_CYCLE_COUNT_EN
    logic [31:0]  res_attempts;
`endif

    hash_ctrl_param #(
        .N_ENTRADAS  (N),
        .NONCE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .num_entradas     (num_entradas),
        .target           (target),
        .start            (start),
        .busy             (busy),
        .bloque_in        (bloque_in),
        .hash_req         (hash_req),
        .hash_ack         (hash_ack),
        .H                (H),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_idx          (res_idx),
        .res_found        (res_found),
        .bounty_out       (bounty_out),
        .nonce_valido_out (nonce_valido_out),
`ifdef HASH_CYCLE_COUNT_EN
        .res_attempts     (res_attempts),
`endif
        .fin              (fin)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [95:0] hdr_mem [N];
    int core_mode = 0;
    int ack_min = 1;
    int ack_max = 1;
    bit spur_arm = 1'b0;
    int req_count = 0;
    int stab_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in hash core: mode 0 hits only at nonce 3, mode 1 never hits, mode 2 mixes bits.
    function automatic logic [23:0] core_hash(input logic [95:0] hdr, input logic [31:0] n, input int mode);
        logic [31:0] x;
        if (mode == 0) return (n == 32'd3) ? 24'h0F0FFF : 24'hFFFFFF;
        if (mode == 1) return 24'hFFFFFF;
        x = hdr[31:0] ^ hdr[63:32] ^ hdr[95:64] ^ (n * 32'h9E3779B1);
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        x = x ^ (x >> 13);
        return x[23:0];
    endfunction

    function automatic bit ref_match(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

    // Core model: acknowledges each request after a chosen number of cycles and
    // watches that the request payload does not move while it waits.
    initial begin : core_model
        int          wait_cnt;
        bit          pending;
        logic [127:0] held;
        pending = 1'b0;
        wait_cnt = 0;
        held = '0;
        forever begin
            @(negedge clk);
            hash_ack = 1'b0;
            H = '0;
            if (!reset_L) begin
                pending = 1'b0;
            end else if (spur_arm && res_valid) begin
                hash_ack = 1'b1;
                H = 24'h000000;
                spur_arm = 1'b0;
            end else if (hash_req) begin
                if (!pending) begin
                    pending = 1'b1;
                    held = bloque_in;
                    wait_cnt = $urandom_range(ack_max, ack_min);
                end else if (bloque_in !== held) begin
                    stab_err++;
                end
                if (wait_cnt == 0) begin
                    hash_ack = 1'b1;
                    H = core_hash(bloque_in[127:32], bloque_in[31:0], core_mode);
                    pending = 1'b0;
                    req_count++;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic wr_hdr(input int a, input logic [95:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        hdr_mem[a] = d;
    endtask

    task automatic do_run(input int num, input logic [7:0] tgt, input int hold, input bit wr_busy);
        int          eff;
        bit          ef [N];
        logic [31:0] en [N];
        logic [23:0] eb [N];
        logic [23:0] hh;
        int          exp_req;
        int          cyc;
        int          fins;
        int          hold_bad;
        logic [58:0] snap;

        eff = (num == 0 || num > N) ? N : num;
        exp_req = 0;
        for (int e = 0; e < eff; e++) begin
            ef[e] = 1'b0;
            en[e] = LIMIT;
            eb[e] = '0;
            for (int n = 0; n <= int'(LIMIT); n++) begin
                hh = core_hash(hdr_mem[e], 32'(n), core_mode);
                if (ref_match(hh, tgt)) begin
                    ef[e] = 1'b1;
                    en[e] = 32'(n);
                    eb[e] = hh;
                    break;
                end
            end
            exp_req += ef[e] ? int'(en[e]) + 1 : int'(LIMIT) + 1;
        end

        req_count = 0;
        stab_err = 0;
        @(negedge clk);
        start = 1'b1;
        num_entradas = 3'(num);
        target = tgt;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        if (wr_busy) begin
            wr_en = 1'b1;
            wr_addr = 2'd0;
            wr_data = ~hdr_mem[0];
            @(negedge clk);
            wr_en = 1'b0;
        end

        for (int e = 0; e < eff; e++) begin
            cyc = 0;
            while (res_valid !== 1'b1 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check("res_valid_timeout", 64'(cyc < 3000), 64'd1);
            if (cyc >= 3000) return;
            if (hold > 0) begin
                hold_bad = 0;
                snap = {res_idx, res_found, bounty_out, nonce_valido_out};
                repeat (hold) begin
                    @(negedge clk);
                    if (res_valid !== 1'b1 || hash_req !== 1'b0 ||
                        {res_idx, res_found, bounty_out, nonce_valido_out} !== snap) hold_bad++;
                end
                check("hold_stable", 64'(hold_bad), 64'd0);
            end
            check("res_idx", 64'(res_idx), 64'(e));
            check("res_found", 64'(res_found), 64'(ef[e]));
            check("nonce_valido_out", 64'(nonce_valido_out), 64'(en[e]));
            check("bounty_out", 64'(bounty_out), 64'(eb[e]));
`ifdef HASH_CYCLE_COUNT_EN
            check("res_attempts", 64'(res_attempts), 64'(en[e] + 32'd1));
`endif
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end

        fins = 0;
        for (int k = 0; k < 4; k++) begin
            if (fin === 1'b1) fins++;
            @(negedge clk);
        end
        check("fin_pulses", 64'(fins), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("req_count", 64'(req_count), 64'(exp_req));
        check("req_stable", 64'(stab_err), 64'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hash_req", 64'(hash_req), 64'd0);
        check("rst_bloque_in", 64'(bloque_in != '0), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_fin", 64'(fin), 64'd0);
        check("rst_res_found", 64'(res_found), 64'd0);
        check("rst_bounty", 64'(bounty_out), 64'd0);
        check("rst_nonce", 64'(nonce_valido_out), 64'd0);
        #2 reset_L = 1'b1;

        for (int a = 0; a < N; a++) wr_hdr(a, {$urandom, $urandom, $urandom});

        // Fixed hit at nonce 3 on two entries.
        core_mode = 0; ack_min = 1; ack_max = 1;
        do_run(2, 8'h10, 0, 1'b0);

        // Never matches: each entry exhausts the nonce range.
        core_mode = 1;
        do_run(1, 8'h10, 0, 1'b0);

        // Consumer back-pressure for 5 cycles.
        core_mode = 0;
        do_run(2, 8'h10, 5, 1'b0);

        // Slow core plus a stray acknowledge while a result is pending.
        ack_min = 3; ack_max = 3; spur_arm = 1'b1;
        do_run(1, 8'h10, 2, 1'b0);
        spur_arm = 1'b0;

        // A zero target can never be met.
        core_mode = 2; ack_min = 0; ack_max = 2;
        do_run(2, 8'h00, 0, 1'b0);

        // Zero entries requested means all slots.
        do_run(0, 8'h60, 0, 1'b0);

        // Header writes are dropped while a run is active.
        do_run(2, 8'h50, 1, 1'b1);

        // Asynchronous reset in the middle of a request.
        ack_min = 6; ack_max = 6;
        @(negedge clk);
        start = 1'b1;
        num_entradas = 3'd2;
        target = 8'h40;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (hash_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("req_before_reset", 64'(hash_req), 64'd1);
        #2 reset_L = 1'b0;
        #1;
        check("midrst_hash_req", 64'(hash_req), 64'd0);
        check("midrst_bloque_in", 64'(bloque_in != '0), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_L = 1'b1;
        ack_min = 0; ack_max = 2;
        do_run(3, 8'h60, 0, 1'b0);

        // Randomised runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < N; a++) wr_hdr(a, {$urandom, $urandom, $urandom});
            ack_min = 0;
            ack_max = int'($urandom_range(3, 0));
            do_run(int'($urandom_range(7, 0)), 8'($urandom_range(8'hC0, 8'h20)),
                   int'($urandom_range(2, 0)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
